// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, handshake FSM state type and opcode legality check for alu_seq.
// The legal opcode set grows when ALU_MULDIV_EN is defined.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0100;
   localparam logic [3:0] ALU_SRA  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_MULU = 4'b1001;
   localparam logic [3:0] ALU_DIVU = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_NOP  = 4'b1111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB,
         ALU_SLT, ALU_SLTU, ALU_NOR, ALU_NOP: legal = 1'b1;
`ifdef ALU_MULDIV_EN
         ALU_MULU, ALU_DIVU:                 legal = 1'b1;
`endif
         default:                            legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider.
// done is high in the final iteration cycle; lo/hi then carry that iteration's result.
module alu_muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] acc_q, acc_d, quo_q, quo_d, opb_q, opb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             run_q, run_d, is_div_q, is_div_d;
   logic [WIDTH:0]   step_sum, rem_sh;

   always_comb begin
      acc_d    = acc_q;
      quo_d    = quo_q;
      opb_d    = opb_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      is_div_d = is_div_q;
      step_sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
      rem_sh   = {acc_q, quo_q[WIDTH-1]};
      if (start) begin
         acc_d    = '0;
         quo_d    = a;
         opb_d    = b;
         cnt_d    = CW'(WIDTH - 1);
         run_d    = 1'b1;
         is_div_d = is_div;
      end else if (run_q) begin
         if (is_div_q) begin
            // remainder stays below the divisor, so the W-bit difference is exact
            if (rem_sh >= {1'b0, opb_q}) begin
               acc_d = rem_sh[WIDTH-1:0] - opb_q;
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rem_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_d = step_sum[WIDTH:1];
            quo_d = {step_sum[0], quo_q[WIDTH-1:1]};
         end
         if (cnt_q == '0) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         quo_q    <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
         is_div_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         quo_q    <= quo_d;
         opb_q    <= opb_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
         is_div_q <= is_div_d;
      end
   end

   assign done = run_q && (cnt_q == '0);
   assign lo   = quo_d;
   assign hi   = acc_d;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with shifts, compares and signed overflow.
// Define ALU_MULDIV_EN to add the iterative MULU/DIVU engine and its BUSY state.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic             alu_zero,
   output logic             alu_pos,
   output logic             alu_ovf,
   output logic             alu_err
);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] res, res_hi, sum, diff;
   logic [SHW-1:0]   shamt;
   logic             ovf, err, accept, ld, ld_ovf, ld_err;
   logic [WIDTH-1:0] ld_lo, ld_hi;
   logic [WIDTH-1:0] out_q, out_d, out_hi_q, out_hi_d;
   logic             valid_q, valid_d, zero_q, zero_d, pos_q, pos_d;
   logic             ovf_q, ovf_d, err_q, err_d;

   always_comb begin : datapath
      res    = '0;
      res_hi = '0;
      ovf    = 1'b0;
      err    = ~is_legal_op(alu_op);
      sum    = alu_a + alu_b;
      diff   = alu_a - alu_b;
      shamt  = alu_b[SHW-1:0];
      case (alu_op)
         ALU_AND:  res = alu_a & alu_b;
         ALU_OR:   res = alu_a | alu_b;
         ALU_ADD: begin
            res = sum;
            ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]);
         end
         ALU_SUB: begin
            res = diff;
            ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (diff[WIDTH-1] != alu_a[WIDTH-1]);
         end
         ALU_SLL:  res = alu_a << shamt;
         ALU_SRL:  res = alu_a >> shamt;
         ALU_SRA:  res = $signed(alu_a) >>> shamt;
         ALU_SLT:  res[0] = $signed(alu_a) < $signed(alu_b);
         ALU_SLTU: res[0] = alu_a < alu_b;
         ALU_NOR:  res = ~(alu_a | alu_b);
         ALU_NOP:  res = alu_a;
`ifdef ALU_MULDIV_EN
         ALU_DIVU: begin
            if (alu_b == '0) begin
               res    = '1;
               res_hi = alu_a;
               err    = 1'b1;
            end
         end
`endif
         default:  ;
      endcase
   end

`ifdef ALU_MULDIV_EN
   state_e           state_q, state_d;
   logic             is_multi, start, md_done;
   logic [WIDTH-1:0] md_lo, md_hi;

   assign is_multi = (alu_op == ALU_MULU) || ((alu_op == ALU_DIVU) && (alu_b != '0));
   assign in_ready = (state_q == ST_IDLE) && (~valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign start    = accept && is_multi;

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .is_div (alu_op == ALU_DIVU),
      .a      (alu_a),
      .b      (alu_b),
      .done   (md_done),
      .lo     (md_lo),
      .hi     (md_hi)
   );

   always_comb begin : fsm_next
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)   state_d = ST_BUSY;
         ST_BUSY: if (md_done) state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin : load_sel
      ld     = accept && !is_multi;
      ld_lo  = res;
      ld_hi  = res_hi;
      ld_ovf = ovf;
      ld_err = err;
      if ((state_q == ST_BUSY) && md_done) begin
         ld     = 1'b1;
         ld_lo  = md_lo;
         ld_hi  = md_hi;
         ld_ovf = 1'b0;
         ld_err = 1'b0;
      end
   end
`else
   assign in_ready = ~valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin : load_sel
      ld     = accept;
      ld_lo  = res;
      ld_hi  = res_hi;
      ld_ovf = ovf;
      ld_err = err;
   end
`endif

   always_comb begin : out_next
      out_d    = out_q;
      out_hi_d = out_hi_q;
      zero_d   = zero_q;
      pos_d    = pos_q;
      ovf_d    = ovf_q;
      err_d    = err_q;
      valid_d  = valid_q;
      if (ld) begin
         out_d    = ld_lo;
         out_hi_d = ld_hi;
         zero_d   = ~|ld_lo;
         pos_d    = ~ld_lo[WIDTH-1] & |ld_lo;
         ovf_d    = ld_ovf;
         err_d    = ld_err;
         valid_d  = 1'b1;
      end else if (out_ready) begin
         valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         out_hi_q <= '0;
         zero_q   <= 1'b0;
         pos_q    <= 1'b0;
         ovf_q    <= 1'b0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         out_q    <= out_d;
         out_hi_q <= out_hi_d;
         zero_q   <= zero_d;
         pos_q    <= pos_d;
         ovf_q    <= ovf_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
      end
   end

   assign out_valid  = valid_q;
   assign alu_out    = out_q;
   assign alu_out_hi = out_hi_q;
   assign alu_zero   = zero_q;
   assign alu_pos    = pos_q;
   assign alu_ovf    = ovf_q;
   assign alu_err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq checked every cycle against an arithmetic model,
// plus literal expectations on the headline results. Honours ALU_MULDIV_EN like the design.
module tb_alu_seq;
   localparam int W = 32;
`ifdef ALU_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif
   localparam longint SMAX = (longint'(1) <<< (W - 1)) - 1;
   localparam longint SMIN = -(longint'(1) <<< (W - 1));

   localparam logic [3:0] OP_AND = 4'h0, OP_OR = 4'h1, OP_ADD = 4'h2, OP_SLL = 4'h3;
   localparam logic [3:0] OP_SRL = 4'h4, OP_SRA = 4'h5, OP_SUB = 4'h6, OP_SLT = 4'h7;
   localparam logic [3:0] OP_SLTU = 4'h8, OP_MULU = 4'h9, OP_DIVU = 4'hA, OP_NOR = 4'hC;
   localparam logic [3:0] OP_NOP = 4'hF;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ovf;
      logic         err;
   } exp_t;

   typedef struct packed {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } vec_t;

   logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
   logic [3:0]   alu_op = '0;
   logic [W-1:0] alu_a = '0, alu_b = '0;
   logic         in_ready, out_valid, alu_zero, alu_pos, alu_ovf, alu_err;
   logic [W-1:0] alu_out, alu_out_hi;
   int           n_vec = 0, n_miss = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_out    (alu_out),
      .alu_out_hi (alu_out_hi),
      .alu_zero   (alu_zero),
      .alu_pos    (alu_pos),
      .alu_ovf    (alu_ovf),
      .alu_err    (alu_err)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t           r;
      longint         sa, sb, s;
      int             sh;
      logic [2*W-1:0] p;
      r  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b % W);
      case (op)
         OP_AND:  r.lo = a & b;
         OP_OR:   r.lo = a | b;
         OP_ADD:  begin s = sa + sb; r.lo = W'(s); r.ovf = (s > SMAX) || (s < SMIN); end
         OP_SUB:  begin s = sa - sb; r.lo = W'(s); r.ovf = (s > SMAX) || (s < SMIN); end
         OP_SLL:  r.lo = a << sh;
         OP_SRL:  r.lo = a >> sh;
         OP_SRA:  begin s = sa >>> sh; r.lo = W'(s); end
         OP_SLT:  r.lo[0] = (sa < sb);
         OP_SLTU: r.lo[0] = (a < b);
         OP_NOR:  r.lo = ~(a | b);
         OP_NOP:  r.lo = a;
         OP_MULU: begin
            if (MD_EN) begin
               p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
               r.lo = p[W-1:0];
               r.hi = p[2*W-1:W];
            end else r.err = 1'b1;
         end
         OP_DIVU: begin
            if (!MD_EN) r.err = 1'b1;
            else if (b == '0) begin r.lo = '1; r.hi = a; r.err = 1'b1; end
            else begin r.lo = a / b; r.hi = a % b; end
         end
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   function automatic logic is_multi(input logic [3:0] op, input logic [W-1:0] b);
      return MD_EN && ((op == OP_MULU) || ((op == OP_DIVU) && (b != '0)));
   endfunction

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Cycle model: what the outputs must show between edges, advanced once per clock.
   logic         m_init = 1'b0, m_valid = 1'b0, m_busy = 1'b0, m_z = 1'b0, m_p = 1'b0;
   int           m_cnt = 0;
   exp_t         m_disp = '0, m_pend = '0;

   always @(negedge clk) begin : cmp
      logic exp_rdy, drained, accept, ld;
      exp_t nxt;
      exp_rdy = !m_busy && (!m_valid || out_ready);
      if (m_init) begin
         chk("out_valid",  out_valid,  m_valid);
         chk("in_ready",   in_ready,   exp_rdy);
         chk("alu_out",    alu_out,    m_disp.lo);
         chk("alu_out_hi", alu_out_hi, m_disp.hi);
         chk("alu_ovf",    alu_ovf,    m_disp.ovf);
         chk("alu_err",    alu_err,    m_disp.err);
         chk("alu_zero",   alu_zero,   m_z);
         chk("alu_pos",    alu_pos,    m_p);
      end
      drained = m_valid && out_ready;
      accept  = in_valid && exp_rdy;
      ld      = 1'b0;
      nxt     = '0;
      if (rst) begin
         m_valid = 1'b0; m_busy = 1'b0; m_disp = '0; m_z = 1'b0; m_p = 1'b0; m_init = 1'b1;
      end else if (m_init) begin
         if (drained) m_valid = 1'b0;
         if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin m_busy = 1'b0; ld = 1'b1; nxt = m_pend; end
         end else if (accept) begin
            if (is_multi(alu_op, alu_b)) begin
               m_busy = 1'b1; m_cnt = W; m_pend = model(alu_op, alu_a, alu_b);
            end else begin
               ld = 1'b1; nxt = model(alu_op, alu_a, alu_b);
            end
         end
         if (ld) begin
            m_valid = 1'b1;
            m_disp  = nxt;
            m_z     = (nxt.lo == '0);
            m_p     = ($signed(nxt.lo) > 0);
         end
      end
   end

   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int   g;
      logic rdy;
      g = 0;
      in_valid = 1'b1; alu_op = op; alu_a = a; alu_b = b;
      do begin
         @(negedge clk); rdy = in_ready;
         @(posedge clk); #1; g++;
      end while (!rdy && g < 100);
      in_valid = 1'b0;
      chk("accept_bound", rdy, 1'b1);
   endtask

   task automatic wait_result(input string name, input int exp_lat);
      int lat;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      chk({name, "_lat"}, lat, exp_lat);
   endtask

   task automatic run(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      send(op, a, b);
      wait_result(name, is_multi(op, b) ? W + 1 : 1);
   endtask

   vec_t vecs [10] = '{
      '{OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00},
      '{OP_OR,   32'h0000_00F0, 32'h0000_000F},
      '{OP_SLL,  32'h0000_0001, 32'h0000_0021},
      '{OP_SRL,  32'h8000_0000, 32'h0000_001F},
      '{OP_SRA,  32'h4000_0000, 32'h0000_0003},
      '{OP_NOR,  32'h0F0F_0F0F, 32'h0000_0000},
      '{OP_NOP,  32'hDEAD_BEEF, 32'h1234_5678},
      '{OP_SUB,  32'h0000_0000, 32'h0000_0001},
      '{OP_ADD,  32'h8000_0000, 32'h8000_0000},
      '{OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF}
   };

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int lat;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_alu_out", alu_out, '0);

      run("add1", OP_ADD, 32'd7, 32'hFFFF_FFFD);
      chk("add1_out", alu_out, 32'd4);
      chk("add1_pos", alu_pos, 1'b1);
      chk("add1_ovf", alu_ovf, 1'b0);

      run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1);
      chk("add_ovf_out", alu_out, 32'h8000_0000);
      chk("add_ovf_ovf", alu_ovf, 1'b1);
      chk("add_ovf_pos", alu_pos, 1'b0);
      run("sub_ovf", OP_SUB, 32'h8000_0000, 32'd1);
      chk("sub_ovf_out", alu_out, 32'h7FFF_FFFF);
      chk("sub_ovf_ovf", alu_ovf, 1'b1);
      run("sub_zero", OP_SUB, 32'd5, 32'd5);
      chk("sub_zero_z", alu_zero, 1'b1);

      run("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1);
      chk("slt_out", alu_out, 32'd1);
      run("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1);
      chk("sltu_out", alu_out, 32'd0);
      run("sra", OP_SRA, 32'h8000_0000, 32'h0000_0024);
      chk("sra_out", alu_out, 32'hF800_0000);

      foreach (vecs[i]) run("vec", vecs[i].op, vecs[i].a, vecs[i].b);

`ifdef ALU_MULDIV_EN
      send(OP_MULU, 32'hFFFF_FFFF, 32'd2);
      lat = 1;
      while (!out_valid && lat < 200) begin
         chk("mulu_busy_ready", in_ready, 1'b0);
         @(posedge clk); #1; lat++;
      end
      chk("mulu_lat", lat, W + 1);
      chk("mulu_lo", alu_out, 32'hFFFF_FFFE);
      chk("mulu_hi", alu_out_hi, 32'd1);
      run("divu", OP_DIVU, 32'd100, 32'd7);
      chk("divu_q", alu_out, 32'd14);
      chk("divu_r", alu_out_hi, 32'd2);
      run("div0", OP_DIVU, 32'd5, 32'd0);
      chk("div0_out", alu_out, 32'hFFFF_FFFF);
      chk("div0_hi", alu_out_hi, 32'd5);
      chk("div0_err", alu_err, 1'b1);
`else
      run("mulu_ill", OP_MULU, 32'hFFFF_FFFF, 32'd2);
      chk("mulu_ill_err", alu_err, 1'b1);
      chk("mulu_ill_out", alu_out, 32'd0);
      run("divu_ill", OP_DIVU, 32'd5, 32'd0);
      chk("divu_ill_err", alu_err, 1'b1);
      chk("divu_ill_hi", alu_out_hi, 32'd0);
`endif

      send(OP_OR, 32'h0000_00F0, 32'h0000_000F);
      out_ready = 1'b0;
      wait_result("bp_or", 1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_hold_out", alu_out, 32'h0000_00FF);
         chk("bp_hold_valid", out_valid, 1'b1);
         chk("bp_hold_ready", in_ready, 1'b0);
      end
      in_valid = 1'b1; alu_op = OP_ADD; alu_a = 32'd1; alu_b = 32'd2; out_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready_up", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_new_valid", out_valid, 1'b1);
      chk("bp_new_out", alu_out, 32'd3);

`ifdef ALU_MULDIV_EN
      send(OP_MULU, 32'h1234_5678, 32'h0000_0010);
      repeat (9) @(posedge clk);
      #1;
      chk("abort_busy_ready", in_ready, 1'b0);
`else
      send(OP_OR, 32'h0000_00AA, 32'h0000_0055);
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_hold_out", alu_out, 32'h0000_00FF);
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      chk("abort_valid", out_valid, 1'b0);
      chk("abort_out", alu_out, 32'd0);
      chk("abort_hi", alu_out_hi, 32'd0);
      chk("abort_ready", in_ready, 1'b1);
      chk("abort_zero", alu_zero, 1'b0);

      run("illegal", 4'b1011, 32'h1234_5678, 32'h0000_0001);
      chk("illegal_err", alu_err, 1'b1);
      chk("illegal_out", alu_out, 32'd0);
      run("illegal_d", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("illegal_d_err", alu_err, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
